// File: rtl/cramer_seq_if.sv
// Bus bundle for cramer_seq: solve request, coefficient RAM read port and result handshake.
// Optional remainder outputs are present only when CRAMER_SEQ_REM_EN is defined.
interface cramer_seq_if;
  logic        start;
  logic        busy;
  logic [4:0]  mem_addr;
  logic        mem_rd;
  logic [11:0] mem_q;
  logic [23:0] val_x;
  logic [23:0] val_y;
  logic        singular;
  logic        out_valid;
  logic        out_ready;
`ifdef CRAMER_SEQ_REM_EN
  logic [23:0] rem_x;
  logic [23:0] rem_y;
`endif

  modport master (
    input  start, mem_q, out_ready,
`ifdef CRAMER_SEQ_REM_EN
    output rem_x, rem_y,
`endif
    output busy, mem_addr, mem_rd, val_x, val_y, singular, out_valid
  );

  modport slave (
    output start, mem_q, out_ready,
`ifdef CRAMER_SEQ_REM_EN
    input  rem_x, rem_y,
`endif
    input  busy, mem_addr, mem_rd, val_x, val_y, singular, out_valid
  );
endinterface

// File: rtl/cramer_seq.sv
// Sequential 2x2 Cramer solver: fetch six coefficients, shared multiplier, two 24-step divisions.
// Define CRAMER_SEQ_REM_EN to add signed remainder outputs rem_x/rem_y.
module cramer_seq #(
  parameter logic [4:0] BASE_ADDR = 5'd0
) (
  input logic        clk,
  input logic        reset,
  cramer_seq_if.master bus
);
  typedef enum logic [2:0] {IDLE, FETCH, MUL, DET, DIV_X, DIV_Y, HOLD} state_t;

  state_t             state_q;
  logic [4:0]         cnt_q;
  logic signed [11:0] w_q [6];
  logic signed [23:0] p_q [6];
  logic [23:0]        dvs_q, quo_q, rem_q, dy_mag_q, qx_q;
  logic               neg_quo_q, dy_neg_q, d_neg_q;
  logic               busy_q, mem_rd_q, singular_q, out_valid_q;
  logic [4:0]         mem_addr_q;
  logic [23:0]        val_x_q, val_y_q;
`ifdef CRAMER_SEQ_REM_EN
  logic               neg_rem_q;
  logic [23:0]        rx_q, rem_x_q, rem_y_q;
  logic [23:0]        rem_s_d;
`endif

  logic signed [11:0] mul_a, mul_b;
  logic signed [23:0] prod_d, det_d, dx_d, dy_d;
  logic [2:0]         widx;
  logic [24:0]        sh_d, trial_d;
  logic [23:0]        rem_nx, quo_nx, quo_s_d;

  function automatic logic [23:0] mag(input logic [23:0] v);
    return v[23] ? -v : v;
  endfunction

  assign widx   = cnt_q[2:0] - 3'd1;
  assign prod_d = mul_a * mul_b;
  assign det_d  = p_q[0] - p_q[1];
  assign dx_d   = p_q[2] - p_q[3];
  assign dy_d   = p_q[4] - p_q[5];

  always_comb begin
    mul_a = '0;
    mul_b = '0;
    case (cnt_q[2:0])
      3'd0: begin mul_a = w_q[0]; mul_b = w_q[3]; end
      3'd1: begin mul_a = w_q[2]; mul_b = w_q[1]; end
      3'd2: begin mul_a = w_q[4]; mul_b = w_q[3]; end
      3'd3: begin mul_a = w_q[5]; mul_b = w_q[1]; end
      3'd4: begin mul_a = w_q[0]; mul_b = w_q[5]; end
      3'd5: begin mul_a = w_q[2]; mul_b = w_q[4]; end
      default: ;
    endcase
  end

  // Restoring division on magnitudes; signs are reapplied on the final step.
  always_comb begin
    sh_d    = {rem_q, quo_q[23]};
    trial_d = sh_d - {1'b0, dvs_q};
    if (!trial_d[24]) begin
      rem_nx = trial_d[23:0];
      quo_nx = {quo_q[22:0], 1'b1};
    end else begin
      rem_nx = sh_d[23:0];
      quo_nx = {quo_q[22:0], 1'b0};
    end
    quo_s_d = neg_quo_q ? -quo_nx : quo_nx;
`ifdef CRAMER_SEQ_REM_EN
    rem_s_d = neg_rem_q ? -rem_nx : rem_nx;
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      for (int unsigned i = 0; i < 6; i++) begin
        w_q[i] <= '0;
        p_q[i] <= '0;
      end
      dvs_q       <= '0;
      quo_q       <= '0;
      rem_q       <= '0;
      dy_mag_q    <= '0;
      qx_q        <= '0;
      neg_quo_q   <= 1'b0;
      dy_neg_q    <= 1'b0;
      d_neg_q     <= 1'b0;
      busy_q      <= 1'b0;
      mem_rd_q    <= 1'b0;
      mem_addr_q  <= BASE_ADDR;
      singular_q  <= 1'b0;
      out_valid_q <= 1'b0;
      val_x_q     <= '0;
      val_y_q     <= '0;
`ifdef CRAMER_SEQ_REM_EN
      neg_rem_q   <= 1'b0;
      rx_q        <= '0;
      rem_x_q     <= '0;
      rem_y_q     <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: if (bus.start) begin
          state_q    <= FETCH;
          busy_q     <= 1'b1;
          mem_rd_q   <= 1'b1;
          mem_addr_q <= BASE_ADDR;
          cnt_q      <= '0;
        end
        // Read data trails the address by one cycle, so capture runs one step behind.
        FETCH: begin
          if (cnt_q != 5'd0) w_q[widx] <= bus.mem_q;
          if (cnt_q < 5'd5) begin
            mem_addr_q <= BASE_ADDR + cnt_q + 5'd1;
          end else begin
            mem_rd_q   <= 1'b0;
            mem_addr_q <= BASE_ADDR;
          end
          if (cnt_q == 5'd6) begin
            state_q <= MUL;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 5'd1;
          end
        end
        MUL: begin
          p_q[cnt_q[2:0]] <= prod_d;
          if (cnt_q == 5'd5) begin
            state_q <= DET;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 5'd1;
          end
        end
        DET: if (det_d == '0) begin
          state_q     <= HOLD;
          singular_q  <= 1'b1;
          out_valid_q <= 1'b1;
          val_x_q     <= '0;
          val_y_q     <= '0;
`ifdef CRAMER_SEQ_REM_EN
          rem_x_q     <= '0;
          rem_y_q     <= '0;
`endif
        end else begin
          state_q    <= DIV_X;
          cnt_q      <= '0;
          singular_q <= 1'b0;
          dvs_q      <= mag(det_d);
          quo_q      <= mag(dx_d);
          rem_q      <= '0;
          neg_quo_q  <= dx_d[23] ^ det_d[23];
          dy_mag_q   <= mag(dy_d);
          dy_neg_q   <= dy_d[23];
          d_neg_q    <= det_d[23];
`ifdef CRAMER_SEQ_REM_EN
          neg_rem_q  <= dx_d[23];
`endif
        end
        DIV_X: begin
          rem_q <= rem_nx;
          quo_q <= quo_nx;
          if (cnt_q == 5'd23) begin
            state_q   <= DIV_Y;
            cnt_q     <= '0;
            qx_q      <= quo_s_d;
            quo_q     <= dy_mag_q;
            rem_q     <= '0;
            neg_quo_q <= dy_neg_q ^ d_neg_q;
`ifdef CRAMER_SEQ_REM_EN
            rx_q      <= rem_s_d;
            neg_rem_q <= dy_neg_q;
`endif
          end else begin
            cnt_q <= cnt_q + 5'd1;
          end
        end
        DIV_Y: begin
          rem_q <= rem_nx;
          quo_q <= quo_nx;
          if (cnt_q == 5'd23) begin
            state_q     <= HOLD;
            cnt_q       <= '0;
            out_valid_q <= 1'b1;
            val_x_q     <= qx_q;
            val_y_q     <= quo_s_d;
`ifdef CRAMER_SEQ_REM_EN
            rem_x_q     <= rx_q;
            rem_y_q     <= rem_s_d;
`endif
          end else begin
            cnt_q <= cnt_q + 5'd1;
          end
        end
        HOLD: if (bus.out_ready) begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.mem_rd    = mem_rd_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.val_x     = val_x_q;
  assign bus.val_y     = val_y_q;
  assign bus.singular  = singular_q;
  assign bus.out_valid = out_valid_q;
`ifdef CRAMER_SEQ_REM_EN
  assign bus.rem_x     = rem_x_q;
  assign bus.rem_y     = rem_y_q;
`endif
endmodule

// File: tb/tb_cramer_seq.sv
// Self-checking bench for cramer_seq: 64-bit reference model feeding an expected-result queue.
module tb_cramer_seq;
  localparam logic [4:0] BASE = 5'd3;

  typedef struct {
    longint vx;
    longint vy;
    longint rx;
    longint ry;
    bit     sing;
    int     lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [11:0] ram [32];
  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;

  cramer_seq_if bus ();
  cramer_seq #(.BASE_ADDR(BASE)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  // Synchronous-read coefficient RAM
  always @(posedge clk) if (bus.mem_rd) bus.mem_q <= ram[bus.mem_addr];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  task automatic load_and_push(input int a, input int b, input int c,
                               input int d, input int e, input int f);
    exp_t   x;
    longint dd, dx, dy;
    int     v[6];
    v = '{a, b, c, d, e, f};
    for (int i = 0; i < 6; i++) ram[int'(BASE) + i] = 12'(v[i]);
    dd = longint'(a) * d - longint'(c) * b;
    dx = longint'(e) * d - longint'(f) * b;
    dy = longint'(a) * f - longint'(c) * e;
    if (dd == 0) begin
      x.vx = 0; x.vy = 0; x.rx = 0; x.ry = 0; x.sing = 1'b1; x.lat = 14;
    end else begin
      x.vx = dx / dd; x.vy = dy / dd; x.rx = dx % dd; x.ry = dy % dd;
      x.sing = 1'b0; x.lat = 62;
    end
    sb.push_back(x);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", bus.busy); end
    checks++; if (bus.mem_rd !== 1'b0) begin errors++; $display("FAIL rst_mem_rd: got %b expected 0", bus.mem_rd); end
    checks++; if (bus.mem_addr !== BASE) begin errors++; $display("FAIL rst_mem_addr: got %0d expected %0d", bus.mem_addr, BASE); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b expected 0", bus.out_valid); end
    checks++; if (bus.singular !== 1'b0) begin errors++; $display("FAIL rst_singular: got %b expected 0", bus.singular); end
    checks++; if (bus.val_x !== 24'd0 || bus.val_y !== 24'd0) begin
      errors++; $display("FAIL rst_vals: got %0d,%0d expected 0,0", $signed(bus.val_x), $signed(bus.val_y));
    end
`ifdef CRAMER_SEQ_REM_EN
    checks++; if (bus.rem_x !== 24'd0 || bus.rem_y !== 24'd0) begin
      errors++; $display("FAIL rst_rems: got %0d,%0d expected 0,0", $signed(bus.rem_x), $signed(bus.rem_y));
    end
`endif
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL rst_idle_after: got busy=%b out_valid=%b expected 0,0", bus.busy, bus.out_valid);
    end
  endtask

  // Full solve: latency, result, HOLD stability, release; poke fires start pulses while busy.
  task automatic test_solve(input int a, input int b, input int c, input int d, input int e,
                            input int f, input int hold, input bit poke, input bit early_ready);
    exp_t x;
    int   n;
    load_and_push(a, b, c, d, e, f);
    bus.out_ready = early_ready;
    @(negedge clk) bus.start = 1'b1;
    @(negedge clk) bus.start = 1'b0;
    n = 0;
    while (!bus.out_valid && n < 200) begin
      bus.start = poke && (n == 10 || n == 45);
      @(negedge clk);
      n++;
    end
    bus.start = 1'b0;
    x = sb.pop_front();
    checks++; if (n != x.lat) begin errors++; $display("FAIL latency: got %0d expected %0d", n, x.lat); end
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL busy_in_hold: got %b expected 1", bus.busy); end
    checks++; if (bus.val_x !== 24'(x.vx)) begin errors++; $display("FAIL val_x: got %0d expected %0d", $signed(bus.val_x), x.vx); end
    checks++; if (bus.val_y !== 24'(x.vy)) begin errors++; $display("FAIL val_y: got %0d expected %0d", $signed(bus.val_y), x.vy); end
    checks++; if (bus.singular !== x.sing) begin errors++; $display("FAIL singular: got %b expected %b", bus.singular, x.sing); end
`ifdef CRAMER_SEQ_REM_EN
    checks++; if (bus.rem_x !== 24'(x.rx)) begin errors++; $display("FAIL rem_x: got %0d expected %0d", $signed(bus.rem_x), x.rx); end
    checks++; if (bus.rem_y !== 24'(x.ry)) begin errors++; $display("FAIL rem_y: got %0d expected %0d", $signed(bus.rem_y), x.ry); end
`endif
    if (early_ready) begin
      @(negedge clk);
      checks++; if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
        errors++; $display("FAIL early_ready_release: got out_valid=%b busy=%b expected 0,0", bus.out_valid, bus.busy);
      end
    end else begin
      for (int i = 0; i < hold; i++) begin
        bus.start = poke && (i == 5);
        @(negedge clk);
        checks++; if (bus.out_valid !== 1'b1 || bus.val_x !== 24'(x.vx) || bus.val_y !== 24'(x.vy)
                      || bus.singular !== x.sing) begin
          errors++; $display("FAIL hold_stable[%0d]: got v=%b x=%0d y=%0d s=%b expected 1,%0d,%0d,%b", i,
                             bus.out_valid, $signed(bus.val_x), $signed(bus.val_y), bus.singular, x.vx, x.vy, x.sing);
        end
        checks++; if (bus.mem_rd !== 1'b0 || bus.mem_addr !== BASE) begin
          errors++; $display("FAIL hold_mem_idle[%0d]: got rd=%b addr=%0d expected 0,%0d", i, bus.mem_rd, bus.mem_addr, BASE);
        end
      end
      bus.out_ready = 1'b1;
      bus.start = poke;
      @(negedge clk);
      bus.out_ready = 1'b0;
      bus.start = 1'b0;
      checks++; if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
        errors++; $display("FAIL release: got out_valid=%b busy=%b expected 0,0", bus.out_valid, bus.busy);
      end
      if (poke) begin
        @(negedge clk);
        checks++; if (bus.busy !== 1'b0) begin
          errors++; $display("FAIL start_on_transfer_ignored: got busy=%b expected 0", bus.busy);
        end
      end
    end
    bus.out_ready = 1'b0;
  endtask

  task automatic test_hold_backpressure();
    test_solve(3, 3, 5, 1, 1, 17, 20, 1'b1, 1'b0);
  endtask

  task automatic test_reset_mid_solve();
    load_and_push(3, 3, 5, 1, 1, 17);
    @(negedge clk) bus.start = 1'b1;
    @(negedge clk) bus.start = 1'b0;
    repeat (40) @(negedge clk);
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL midsolve_busy: got %b expected 1", bus.busy); end
    reset = 1'b0;
    #1;
    checks++; if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0 || bus.singular !== 1'b0 || bus.mem_rd !== 1'b0) begin
      errors++; $display("FAIL abort_flags: got busy=%b ov=%b sing=%b rd=%b expected 0,0,0,0",
                         bus.busy, bus.out_valid, bus.singular, bus.mem_rd);
    end
    checks++; if (bus.val_x !== 24'd0 || bus.val_y !== 24'd0 || bus.mem_addr !== BASE) begin
      errors++; $display("FAIL abort_vals: got x=%0d y=%0d addr=%0d expected 0,0,%0d",
                         $signed(bus.val_x), $signed(bus.val_y), bus.mem_addr, BASE);
    end
    sb.delete();
    @(negedge clk) reset = 1'b1;
    test_solve(3, 3, 5, 1, 1, 17, 2, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    test_solve(2, 1, 1, -1, 5, 1, 0, 1'b0, 1'b1);
    test_solve(1, 2, 2, 4, 7, 9, 0, 1'b0, 1'b1);
    test_solve(-2048, 2047, 2047, -2048, -2048, 2047, 0, 1'b0, 1'b1);
  endtask

  task automatic test_random();
    int v[6];
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 6; i++) v[i] = int'($urandom_range(0, 4095)) - 2048;
      test_solve(v[0], v[1], v[2], v[3], v[4], v[5], 1, 1'b0, 1'b0);
    end
  endtask

  initial begin
    bus.start = 1'b0;
    bus.out_ready = 1'b0;
    test_reset();
    test_solve(3, 3, 5, 1, 1, 17, 2, 1'b0, 1'b0);
    test_solve(2, 1, 1, -1, 5, 1, 2, 1'b0, 1'b0);
    test_solve(1, 2, 2, 4, 7, 9, 2, 1'b0, 1'b0);
    test_solve(-2048, 2047, 2047, -2048, -2048, 2047, 2, 1'b0, 1'b0);
    test_hold_backpressure();
    test_reset_mid_solve();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
